// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
// Module  : softmax_pkg
// Brief   : Shared types and constants for the softmax initiator blocks.
// Revision: 1.0 - initial release
// ============================================================================
package softmax_pkg;

    localparam int ARITH_FLOAT = 0;
    localparam int ARITH_FIXED = 1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_INTEGER    = 10;
    localparam int DEF_FRACTION   = 22;
    localparam int DEF_E          = 8;
    localparam int DEF_M          = 23;

    typedef enum logic [1:0] {
        STATE_COLLECT = 2'd0,
        STATE_LAUNCH  = 2'd1,
        STATE_WAIT    = 2'd2,
        STATE_DRAIN   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/softmax_max_cmp.sv
`default_nettype none
// ============================================================================
// Module  : softmax_max_cmp
// Brief   : Combinational a > b for fixed-point or sign/magnitude float scores.
// Revision: 1.0 - initial release
// ============================================================================
module softmax_max_cmp
    import softmax_pkg::*;
#(
    parameter int ARITH_TYPE = ARITH_FIXED,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int E          = DEF_E,
    parameter int M          = DEF_M
)(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    localparam int MAG_W = E + M;

    logic w_fix_gt;
    logic w_flt_gt;
    logic w_sign_a;
    logic w_sign_b;
    logic [MAG_W-1:0] w_mag_a;
    logic [MAG_W-1:0] w_mag_b;

    assign w_fix_gt = $signed(a) > $signed(b);
    assign w_sign_a = a[DATA_WIDTH-1];
    assign w_sign_b = b[DATA_WIDTH-1];
    assign w_mag_a  = a[MAG_W-1:0];
    assign w_mag_b  = b[MAG_W-1:0];

    // Both zero magnitudes compare equal regardless of sign (+0 == -0).
    always_comb begin
        w_flt_gt = 1'b0;
        if ((w_mag_a == '0) && (w_mag_b == '0)) begin
            w_flt_gt = 1'b0;
        end else if (w_sign_a != w_sign_b) begin
            w_flt_gt = ~w_sign_a;
        end else if (!w_sign_a) begin
            w_flt_gt = w_mag_a > w_mag_b;
        end else begin
            w_flt_gt = w_mag_a < w_mag_b;
        end
    end

    assign a_gt_b = (ARITH_TYPE == ARITH_FIXED) ? w_fix_gt : w_flt_gt;

endmodule
`default_nettype wire

// File: rtl/softmax_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : softmax_sequencer
// Brief   : Collects four scores, launches softmax, replays its four results.
// Revision: 1.0 - initial release
// ============================================================================
module softmax_sequencer
    import softmax_pkg::*;
#(
    parameter int ARITH_TYPE     = ARITH_FIXED,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int INTEGER        = DEF_INTEGER,
    parameter int FRACTION       = DEF_FRACTION,
    parameter int E              = DEF_E,
    parameter int M              = DEF_M,
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  softmax_enable,
    output logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH-1:0] in3,
    output logic [DATA_WIDTH-1:0] in4,
    output logic [DATA_WIDTH-1:0] max_input,
    input  logic [DATA_WIDTH-1:0] softmax_out_1,
    input  logic [DATA_WIDTH-1:0] softmax_out_2,
    input  logic [DATA_WIDTH-1:0] softmax_out_3,
    input  logic [DATA_WIDTH-1:0] softmax_out_4,
    input  logic                  softmax_output_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            m_index,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [1:0] ST_COLLECT = STATE_COLLECT;
    localparam logic [1:0] ST_LAUNCH  = STATE_LAUNCH;
    localparam logic [1:0] ST_WAIT    = STATE_WAIT;
    localparam logic [1:0] ST_DRAIN   = STATE_DRAIN;

    localparam int C_WCNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [C_WCNT_W-1:0] C_WAIT_LAST = C_WCNT_W'(TIMEOUT_CYCLES - 1);
    // Comparator width follows the split of whichever number format is active.
    localparam int C_CMP_W = (ARITH_TYPE == ARITH_FIXED) ? (INTEGER + FRACTION) : (1 + E + M);

    logic [1:0]            r_state;
    logic [1:0]            r_acc_cnt;
    logic [DATA_WIDTH-1:0] r_in [4];
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] r_buf [4];
    logic [1:0]            r_idx;
    logic [C_WCNT_W-1:0]   r_wait_cnt;
    logic                  r_rdy_q;

    logic w_gt;
    logic w_accept;
    logic w_capture;
    logic w_timeout;

    softmax_max_cmp #(
        .ARITH_TYPE (ARITH_TYPE),
        .DATA_WIDTH (C_CMP_W),
        .E          (E),
        .M          (M)
    ) u_max_cmp (
        .a      (s_data),
        .b      (r_max),
        .a_gt_b (w_gt)
    );

    assign w_accept  = s_valid && (r_state == ST_COLLECT);
    // Only a fresh rising edge counts; a level left high from earlier is stale.
    assign w_capture = (r_state == ST_WAIT) && softmax_output_ready && !r_rdy_q;
    assign w_timeout = (r_state == ST_WAIT) && !w_capture && (r_wait_cnt == C_WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_COLLECT;
            r_acc_cnt  <= 2'd0;
            r_max      <= '0;
            r_idx      <= 2'd0;
            r_wait_cnt <= '0;
            r_rdy_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_in[i]  <= '0;
                r_buf[i] <= '0;
            end
        end else begin
            r_rdy_q <= softmax_output_ready;
            case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_in[r_acc_cnt] <= s_data;
                        if ((r_acc_cnt == 2'd0) || w_gt) begin
                            r_max <= s_data;
                        end
                        r_acc_cnt <= r_acc_cnt + 2'd1;
                        if (r_acc_cnt == 2'd3) begin
                            r_state <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_buf[0] <= softmax_out_1;
                        r_buf[1] <= softmax_out_2;
                        r_buf[2] <= softmax_out_3;
                        r_buf[3] <= softmax_out_4;
                        r_idx    <= 2'd0;
                        r_state  <= ST_DRAIN;
                    end else if (w_timeout) begin
                        for (int i = 0; i < 4; i++) begin
                            r_buf[i] <= '0;
                        end
                        r_idx   <= 2'd0;
                        r_state <= ST_COLLECT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    if (m_ready) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= ST_COLLECT;
                        end
                    end
                end
            endcase
        end
    end

    assign s_ready        = (r_state == ST_COLLECT);
    assign busy           = (r_state != ST_COLLECT);
    assign softmax_enable = (r_state == ST_LAUNCH);
    assign m_valid        = (r_state == ST_DRAIN);
    assign m_last         = (r_state == ST_DRAIN) && (r_idx == 2'd3);
    assign m_index        = r_idx;
    assign m_data         = r_buf[r_idx];
    assign timeout_err    = w_timeout;

    assign in1       = r_in[0];
    assign in2       = r_in[1];
    assign in3       = r_in[2];
    assign in4       = r_in[3];
    assign max_input = r_max;

endmodule
`default_nettype wire

// File: doc/softmax_sequencer.md
# softmax_sequencer

Initiator-side controller for the 4-input `softmax` block. It accepts a stream of four scores over a valid/ready input port and tracks their running maximum. It then launches `softmax` with a one-cycle `softmax_enable` pulse and holds `in1..in4`/`max_input` stable until the result arrives. Finally it captures `softmax_out_1..4` and replays them as an indexed, back-pressurable output stream.

## Interface
- `ARITH_TYPE`, 1: number format. 0 = IEEE-style float (E/M fields); 1 = signed fixed-point Q(INTEGER.FRACTION).
- `DATA_WIDTH`, 32: width of scores and probabilities.
- `INTEGER`, 10 / `FRACTION`, 22: fixed-point split. INTEGER+FRACTION = DATA_WIDTH.
- `E`, 8 / `M`, 23: float exponent and mantissa widths. 1+E+M = DATA_WIDTH.
- `TIMEOUT_CYCLES`, 64: maximum number of WAIT cycles before the transaction is abandoned. Must be ≥ 2.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `s_valid` in 1 / `s_data` in DATA_WIDTH / `s_ready` out 1: score input stream.
- `softmax_enable` out 1: one-cycle launch pulse to `softmax`.
- `in1`,`in2`,`in3`,`in4`,`max_input` out DATA_WIDTH each: operands driven to `softmax`.
- `softmax_out_1..4` in DATA_WIDTH each / `softmax_output_ready` in 1: results from `softmax`.
- `m_valid` out 1 / `m_data` out DATA_WIDTH / `m_index` out 2 / `m_last` out 1 / `m_ready` in 1: probability output stream.
- `busy` out 1: high in every state except COLLECT.
- `timeout_err` out 1: one-cycle pulse when a transaction is abandoned.

## Operation
- **States:** COLLECT → LAUNCH → WAIT → DRAIN → COLLECT. WAIT also exits to COLLECT on timeout.
- **COLLECT:**
  - `s_ready`=1.
  - Accept k (k=0..3) happens on `s_valid && s_ready` and loads `in(k+1)`.
  - Accept 0 loads `max_input` unconditionally. Later accepts replace `max_input` only if the new value is strictly greater; ties keep the current value.
  - The 4th accept moves to LAUNCH.
- **Compare rules:**
  - Fixed: two's-complement signed compare.
  - Float: if signs differ, the positive operand is greater. If both are positive, the larger magnitude field is greater. If both are negative, the smaller magnitude field is greater. +0 and −0 are equal. No NaN/Inf handling.
- **LAUNCH:** `softmax_enable`=1 for exactly this one cycle, then go to WAIT. `in1..4`/`max_input` stay frozen from the 4th accept until re-entry into COLLECT.
- **WAIT:**
  - Capture condition: a rising edge of `softmax_output_ready` (current=1, previous-cycle=0). A level held high from an earlier transaction never triggers a capture.
  - On capture, `softmax_out_1..4` are registered into an internal buffer and the state moves to DRAIN.
  - A wait counter starts at 0 on entry and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES−1 without a capture, `timeout_err` pulses, the buffer is discarded, and the state returns to COLLECT.
- **DRAIN:**
  - `m_valid`=1, `m_data`=buffer[idx], `m_index`=idx, `m_last`=(idx==3).
  - idx advances on `m_valid && m_ready`. The handshake on idx 3 returns the state to COLLECT.
  - All `m_*` outputs stay stable while `m_ready`=0.
- **Reset:** asserting `reset` in any state, including mid-WAIT or mid-DRAIN, aborts the transaction immediately. No `timeout_err` is produced.

## Timing
- **Reset values:**
  - state=COLLECT, so `s_ready`=1.
  - `softmax_enable`, `m_valid`, `m_last`, `busy`, `timeout_err` = 0.
  - `in1..4`, `max_input`, `m_data` = 0; `m_index`=0.
  - Edge-detect register = 0.
- `s_ready` and `m_valid` are decoded from state only; there is no combinational path from `s_valid` or `m_ready`.
- **Latency:**
  - `softmax_enable` is high in the cycle after the 4th accept.
  - The first `m_valid` is high in the cycle after the capture edge.
  - With `m_ready` held at 1, DRAIN lasts 4 cycles.
- The first COLLECT accept of the next transaction can occur in the cycle after the last DRAIN handshake, or in the cycle after `timeout_err`.
- `softmax_output_ready` asserted during COLLECT, LAUNCH or DRAIN is ignored, but the edge-detect register still tracks it every cycle.

## Structure
- **Package `softmax_pkg`:**
  - state enum (COLLECT, LAUNCH, WAIT, DRAIN);
  - ARITH_FLOAT=0 / ARITH_FIXED=1 constants;
  - default widths (32/10/22/8/23).
- **Sub-module `softmax_max_cmp`:** combinational `a > b` per ARITH_TYPE, with parameters DATA_WIDTH/E/M. Reusable by other max-tracking blocks.

## Test plan
- **Fixed baseline:**
  - Stimulus: stream 0x01C40000 (7.0625), 0x02A00000 (10.5), 0x02C00000 (11.0), 0x00000000, with `s_valid` held high.
  - Required: `max_input`=0x02C00000; `in1..4` equal the inputs; `softmax_enable` high for exactly one cycle, one cycle after the 4th accept.
- **Fixed negatives and ties:**
  - Stimulus: 0xFFC00000 (−1.0), 0xFF800000 (−2.0), 0xFFE00000 (−0.5), 0xFFE00000.
  - Required: `max_input`=0xFFE00000, taken from the 3rd word.
- **Float mode (ARITH_TYPE=0):**
  - 0x412A0000, 0x410E0000, 0x41300000, 0x00000000 → `max_input`=0x41300000.
  - 0xBF800000, 0x80000000, 0x00000000, 0xC0000000 → `max_input`=0x80000000 (the first zero is kept on the tie).
- **Capture and back-pressure:**
  - Stimulus: `softmax_output_ready` rises 3 cycles after enable with outputs 0x11,0x22,0x33,0x44; `m_ready` toggles 1,0,0,1,1,1.
  - Required: stream 0x11/0,0x22/1,0x33/2,0x44/3 with `m_last` only on index 3; `m_*` stable during stalls; `s_ready` returns 1 the cycle after the last handshake.
- **Stale ready and timeout:**
  - Stimulus: hold `softmax_output_ready`=1 from before LAUNCH and never drop it.
  - Required: no capture; `timeout_err` pulses after TIMEOUT_CYCLES WAIT cycles (64 by default); state returns to COLLECT.
- **Reset mid-operation:**
  - Stimulus: assert `reset` during WAIT, then again during DRAIN at idx 2.
  - Required: all outputs take their reset values asynchronously; no `timeout_err`; the next 4-word transaction completes normally.
